// File: rtl/note_sequencer_pkg.sv
// Shared encodings for the note sequencer: FSM states, lane bit positions,
// the rest pattern and the default note pattern used by the ROM.
package note_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_RUN    = 4'b0010,
    ST_DONE   = 4'b0100,
    ST_PAUSED = 4'b1000
  } state_t;

  localparam int LANE_R = 2;
  localparam int LANE_G = 1;
  localparam int LANE_B = 0;

  localparam logic [2:0] REST = 3'b000;
  localparam logic [2:0] L_R  = 3'b001 << LANE_R;
  localparam logic [2:0] L_G  = 3'b001 << LANE_G;
  localparam logic [2:0] L_B  = 3'b001 << LANE_B;

  function automatic logic [2:0] default_pattern(input logic [3:0] idx);
    logic [2:0] p;
    case (idx)
      4'd0:    p = REST;
      4'd1:    p = L_B;
      4'd2:    p = L_G;
      4'd3:    p = L_R;
      4'd4:    p = L_B;
      4'd5:    p = L_G;
      4'd6:    p = L_R;
      4'd7:    p = L_R | L_G | L_B;
      4'd8:    p = L_G;
      4'd9:    p = L_R | L_B;
      4'd10:   p = L_G;
      4'd11:   p = L_R | L_B;
      4'd12:   p = L_G;
      4'd13:   p = L_R | L_B;
      4'd14:   p = L_G | L_B;
      default: p = REST;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/note_rom.sv
// Pattern ROM: NUM_NOTES x LANES, synchronous read with one cycle of latency.
// Swap the contents here without touching the sequencer FSM.
module note_rom
  import note_sequencer_pkg::*;
#(
  parameter int NUM_NOTES = 16,
  parameter int LANES     = 3
) (
  input  logic                         clk,
  input  logic [$clog2(NUM_NOTES)-1:0] addr,
  output logic [LANES-1:0]             data
);

  always_ff @(posedge clk) begin
    data <= LANES'(default_pattern(4'(addr)));
  end

endmodule

// File: rtl/note_sequencer.sv
// Steps the note pattern every STEP_TICKS ticks and issues one valid/ready spawn per non-rest note.
// Request appears one cycle after the step tick; a stalled request freezes the interval counter.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int NUM_NOTES  = 16,
  parameter int STEP_TICKS = 64,
  parameter int LANES      = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         tick,
  input  logic                         start,
  input  logic                         pause,
  input  logic                         restart,
  output logic                         spawn_valid,
  output logic [LANES-1:0]             spawn_lanes,
  input  logic                         spawn_ready,
  output logic [$clog2(NUM_NOTES)-1:0] note_index,
  output logic [7:0]                   issued_count,
  output logic                         playing,
  output logic                         done
);

  localparam int IW = $clog2(NUM_NOTES);
  localparam int CW = $clog2(STEP_TICKS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NOTES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STEP_TICKS - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             last_pend;
  logic [LANES-1:0] rom_data;
  logic             xfer;
  logic             stall;
  logic             at_last;

  // note_index only moves on a step and steps are >= 2 ticks apart, so the
  // registered ROM word already matches note_index when the step tick arrives.
  note_rom #(
    .NUM_NOTES (NUM_NOTES),
    .LANES     (LANES)
  ) u_rom (
    .clk  (clk),
    .addr (note_index),
    .data (rom_data)
  );

  assign xfer    = spawn_valid && spawn_ready;
  assign stall   = spawn_valid && !spawn_ready;
  assign at_last = (note_index == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      note_index   <= '0;
      spawn_valid  <= 1'b0;
      spawn_lanes  <= '0;
      issued_count <= '0;
      last_pend    <= 1'b0;
      playing      <= 1'b0;
      done         <= 1'b0;
    end else if (restart) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      note_index   <= '0;
      spawn_valid  <= 1'b0;
      spawn_lanes  <= '0;
      issued_count <= '0;
      last_pend    <= 1'b0;
      playing      <= 1'b0;
      done         <= 1'b0;
    end else begin
      if (xfer) begin
        spawn_valid <= 1'b0;
        if (issued_count != 8'hFF) begin
          issued_count <= issued_count + 8'd1;
        end
      end

      unique case (state)
        ST_IDLE: begin
          if (start && !pause) begin
            state   <= ST_RUN;
            cnt     <= '0;
            playing <= 1'b1;
          end
        end

        ST_RUN: begin
          if (last_pend && (xfer || !spawn_valid)) begin
            state     <= ST_DONE;
            last_pend <= 1'b0;
            playing   <= 1'b0;
            done      <= 1'b1;
          end else if (pause) begin
            state <= ST_PAUSED;
          end else if (tick && !stall) begin
            if (cnt == CNT_MAX) begin
              cnt        <= '0;
              note_index <= at_last ? '0 : note_index + IW'(1);
              if (rom_data != LANES'(REST)) begin
                spawn_valid <= 1'b1;
                spawn_lanes <= rom_data;
                last_pend   <= at_last;
              end else if (at_last) begin
                state   <= ST_DONE;
                playing <= 1'b0;
                done    <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end

        ST_PAUSED: begin
          // A request pending at pause time may still complete and finish the pattern.
          if (last_pend && (xfer || !spawn_valid)) begin
            state     <= ST_DONE;
            last_pend <= 1'b0;
            playing   <= 1'b0;
            done      <= 1'b1;
          end else if (!pause) begin
            state <= ST_RUN;
          end
        end

        ST_DONE: begin
          state <= ST_DONE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
